servo_pwm_bank: RTL
===================

// Module: servo_pwm_bank
//
// PURPOSE
//  Downstream consumer of the AXI-lite register block: turns per-servo pulse-width values
//  written by that block into hobby-servo PWM pins, one per quadruped joint (4 legs x 3 joints).
//  Writes land in staging registers; a commit is applied atomically at the next frame boundary,
//  so every joint of a pose changes on the same frame.
//
// PARAMETERS
//  N_CH       12       number of servo channels
//  TICK_DIV   100      s_axi_aclk cycles per 1 us tick (100 MHz clock)
//  PERIOD_US  20000    frame period in us ticks (50 Hz); must be <= 65535
//  W_MIN      500      minimum accepted pulse width, us
//  W_MAX      2500     maximum accepted pulse width, us
//  CH_W       4        channel index width, >= clog2(N_CH)
//
// PORTS
//  s_axi_aclk     in   1      clock
//  s_axi_aresetn  in   1      asynchronous active-low reset
//  enable         in   1      global output enable (level)
//  pw_wr_en       in   1      staging write strobe, one cycle
//  pw_wr_ch       in   CH_W   channel index for write
//  pw_wr_data     in   16     pulse width, us
//  commit         in   1      request staging->active transfer at next frame boundary, one cycle
//  commit_pend    out  1      commit requested, not yet applied
//  commit_ack     out  1      one-cycle pulse when staging copied to active
//  wr_err         out  1      one-cycle pulse, write to channel >= N_CH (ignored)
//  frame_start    out  1      one-cycle pulse at frame-counter wrap to 0
//  pwm_out        out  N_CH   servo pins
//
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0; prescaler, frame counter, staging[], active[] = 0.
//    active = 0 means no pulse on that channel.
//  - Prescaler counts 0..TICK_DIV-1 every clock; tick = (presc == TICK_DIV-1).
//  - Frame counter fcnt (16 b) advances on tick, 0..PERIOD_US-1, wraps to 0;
//    frame_start registered, asserted the cycle after the tick that wraps fcnt.
//  - Write: pw_wr_en && pw_wr_ch < N_CH -> staging[ch] <= clamp(pw_wr_data, W_MIN, W_MAX) next cycle.
//    pw_wr_ch >= N_CH -> no state change, wr_err pulses next cycle.
//  - commit sets commit_pend (next cycle). At the boundary cycle (tick && fcnt == PERIOD_US-1)
//    with commit_pend already 1: active[] <= staging[] (all channels together), commit_pend <= 0,
//    commit_ack pulses next cycle.
//  - Simultaneous events at boundary cycle: commit arriving that cycle is not applied, sets
//    commit_pend, applies next frame; a staging write that cycle is not seen by the copy
//    (active gets pre-write value). Repeated commits while pending: no effect beyond pend=1.
//  - pwm_out[i] registered: 1 iff enable && (fcnt < active[i]); fcnt and active update same edge
//    as boundary, so a new width starts exactly at fcnt = 0. Latency: 1 clock from fcnt.
//  - enable low: pwm_out forced 0 next cycle, counters/commit logic keep running;
//    enable high mid-frame resumes on comparison immediately (may give a partial first pulse).
//  - Pulse widths are 1 us quantised; high time = active[i] * TICK_DIV clocks.
//  - Reset mid-pulse: pwm_out drops to 0 asynchronously, pending commit discarded.
//
// STRUCTURE
//  - Package servo_pkg: TICK_DIV, PERIOD_US, W_MIN, W_MAX defaults, N_CH, PW_W = 16, clamp function.
//  - Top: prescaler, frame counter, staging array, commit FSM (IDLE / PEND), write decode.
//  - Sub-module servo_pwm_ch (one per channel via generate): holds active width,
//    loads on boundary-commit strobe, registered compare against shared fcnt.
//
// TESTING (sim with TICK_DIV=2, PERIOD_US=3000 to shorten frames)
//  - write ch3=1500, commit -> commit_ack at next boundary; pwm_out[3] high exactly 3000 clocks/frame, others 0.
//  - write ch0=100, ch1=3000, commit -> widths 500 and 2500 us (1000 / 5000 clocks).
//  - write ch=12 data=1000 -> wr_err one cycle, staging unchanged, no commit_pend change.
//  - commit on boundary cycle -> commit_pend stays 1, applied one frame later (ack 3000*2 clocks later).
//  - write ch5=1200, commit, then write ch5=2000 before boundary -> frame uses 2000 (staging copied at boundary).
//  - enable=0 mid-pulse -> pwm_out 0 next cycle; aresetn low mid-pulse -> all outputs 0 immediately, active=0.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants, commit-state encoding and the pulse-width clamp for the servo PWM bank.
package servo_pkg;

  localparam int DEF_N_CH      = 12;
  localparam int DEF_TICK_DIV  = 100;
  localparam int DEF_PERIOD_US = 20000;
  localparam int DEF_W_MIN     = 500;
  localparam int DEF_W_MAX     = 2500;
  localparam int DEF_CH_W      = 4;
  localparam int PW_W          = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } commit_st_e;

  function automatic logic [PW_W-1:0] clamp_pw(input logic [PW_W-1:0] v,
                                                input logic [PW_W-1:0] lo,
                                                input logic [PW_W-1:0] hi);
    logic [PW_W-1:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// One servo channel: active width register loaded on the commit strobe, registered compare
// against the shared frame counter.
module servo_pwm_ch
  import servo_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  input  logic            load_i,
  input  logic [PW_W-1:0] width_i,
  input  logic [PW_W-1:0] fcnt_i,
  output logic            pwm_o
);

  logic [PW_W-1:0] active_q;
  logic            pwm_q;
  logic            pwm_d;

  // A width of 0 never satisfies the compare, so an unloaded channel stays low.
  assign pwm_d = enable_i && (fcnt_i < active_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
      if (load_i) active_q <= width_i;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_pwm_bank.sv
// Bank of hobby-servo PWM outputs with staged widths that switch atomically on a frame boundary.
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int PERIOD_US = DEF_PERIOD_US,
  parameter int W_MIN     = DEF_W_MIN,
  parameter int W_MAX     = DEF_W_MAX,
  parameter int CH_W      = DEF_CH_W
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_aresetn,
  input  logic             enable,
  input  logic             pw_wr_en,
  input  logic [CH_W-1:0]  pw_wr_ch,
  input  logic [PW_W-1:0]  pw_wr_data,
  input  logic             commit,
  output logic             commit_pend,
  output logic             commit_ack,
  output logic             wr_err,
  output logic             frame_start,
  output logic [N_CH-1:0]  pwm_out
);

  localparam int              PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PW_W-1:0] FCNT_LAST  = PW_W'(PERIOD_US - 1);
  localparam logic [CH_W:0]   N_CH_L     = (CH_W + 1)'(N_CH);
  localparam logic [PW_W-1:0] W_MIN_L    = PW_W'(W_MIN);
  localparam logic [PW_W-1:0] W_MAX_L    = PW_W'(W_MAX);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PW_W-1:0]    fcnt_q, fcnt_d;
  logic [PW_W-1:0]    staging_q [N_CH];
  commit_st_e         state_q;
  logic               frame_start_q, wr_err_q, commit_ack_q;
  logic               tick, boundary, wr_ok, load;

  assign tick     = (presc_q == PRESC_LAST);
  assign boundary = tick && (fcnt_q == FCNT_LAST);
  assign wr_ok    = pw_wr_en && ({1'b0, pw_wr_ch} < N_CH_L);
  // Copy happens only for a commit that was already pending before the boundary cycle.
  assign load     = (state_q == ST_PEND) && boundary;

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    fcnt_d  = fcnt_q;
    if (tick) fcnt_d = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + 1'b1;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      presc_q       <= '0;
      fcnt_q        <= '0;
      state_q       <= ST_IDLE;
      frame_start_q <= 1'b0;
      wr_err_q      <= 1'b0;
      commit_ack_q  <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      fcnt_q        <= fcnt_d;
      frame_start_q <= boundary;
      wr_err_q      <= pw_wr_en && !wr_ok;
      commit_ack_q  <= load;
      case (state_q)
        ST_IDLE: if (commit) state_q <= ST_PEND;
        ST_PEND: if (boundary) state_q <= commit ? ST_PEND : ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < N_CH; i++) staging_q[i] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < N_CH; i++)
        if (pw_wr_ch == CH_W'(i)) staging_q[i] <= clamp_pw(pw_wr_data, W_MIN_L, W_MAX_L);
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    servo_pwm_ch u_ch (
      .clk_i    (s_axi_aclk),
      .rst_ni   (s_axi_aresetn),
      .enable_i (enable),
      .load_i   (load),
      .width_i  (staging_q[gi]),
      .fcnt_i   (fcnt_q),
      .pwm_o    (pwm_out[gi])
    );
  end

  assign commit_pend = (state_q == ST_PEND);
  assign commit_ack  = commit_ack_q;
  assign wr_err      = wr_err_q;
  assign frame_start = frame_start_q;

endmodule
